// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: valid/ready stage register with optional skid buffer, flush and flush counter
module pipeline_stage_reg #(
    parameter int CTRL_W   = 12,
    parameter int DATA_W   = 128,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic              main_v, skid_v, rdy_q, acc, con;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    assign in_ready  = (SKID != 0) ? (rdy_q && !rst) : (out_ready || !main_v);
    assign acc       = in_valid && in_ready;
    assign con       = main_v && out_ready;
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign out_data  = main_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            rdy_q     <= 1'b1;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush && main_v && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (flush) begin
                main_v    <= 1'b0;
                skid_v    <= 1'b0;
                rdy_q     <= 1'b1;
                main_ctrl <= '0;
                if (CLR_DATA != 0)
                    main_data <= '0;
            end else begin
                if (acc && (!main_v || con)) begin
                    main_v    <= 1'b1;
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                end else if (acc) begin
                    skid_v    <= 1'b1;
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                end else if (con && skid_v) begin
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                    skid_v    <= 1'b0;
                end else if (con) begin
                    main_v <= 1'b0;
                end
                rdy_q <= !(skid_v ? !con : (main_v && acc && !con));
            end
        end
    end
endmodule
